// File: rtl/usb_time_endp_pkg.sv
// Shared types for the time-publishing USB IN endpoint.
package usb_time_endp_pkg;

    // Status byte bit positions.
    localparam int STAT_SYNC = 0;
    localparam int STAT_ERR  = 1;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        SEND
    } endp_state_t;

    // Last member lands in the low byte, so byte N of the packet is bits [8N+7:8N].
    typedef struct packed {
        logic [7:0] status;
        logic [7:0] dow;
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] sec;
    } time_pkt_t;

    // Select packet byte idx (0 = seconds ... 7 = status).
    function automatic logic [7:0] pkt_byte(input time_pkt_t p, input logic [2:0] idx);
        logic [63:0] flat;
        flat = p;
        return flat[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/usb_time_endp_snapshot.sv
// Seconds change detector, sync latch, shadow snapshot and pending flag.
module time_snapshot
    import usb_time_endp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] year,
    input  logic [7:0] month,
    input  logic [7:0] day,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [2:0] day_of_week,
    input  logic       dcf77_sync,
    input  logic       dcf77_error,
    input  logic       load_take,
    input  logic       rearm,
    output time_pkt_t  shadow,
    output logic       pending
);

    logic [7:0] sec_q, sec_d;
    logic       sync_seen_q, sync_seen_d;
    time_pkt_t  shadow_q, shadow_d;
    logic       pending_q, pending_d;
    logic       capture;

    // Detect the seconds edge and build the next shadow / latch state.
    always_comb begin
        capture     = (second != sec_q);
        sec_d       = second;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        // A sync pulse in the capture cycle belongs to the following snapshot.
        sync_seen_d = capture ? dcf77_sync : (sync_seen_q | dcf77_sync);

        if (capture) begin
            shadow_d.sec               = second;
            shadow_d.minute            = minute;
            shadow_d.hour              = hour;
            shadow_d.day               = day;
            shadow_d.month             = month;
            shadow_d.year              = year;
            shadow_d.dow               = {5'b0, day_of_week};
            shadow_d.status            = 8'h00;
            shadow_d.status[STAT_SYNC] = sync_seen_q;
            shadow_d.status[STAT_ERR]  = dcf77_error;
        end

        if (load_take) pending_d = 1'b0;
        // A bus reset mid-packet re-offers whatever the shadow holds.
        if (rearm)     pending_d = 1'b1;
        // A fresh capture always wins over a same-cycle load.
        if (capture)   pending_d = 1'b1;
    end

    // Snapshot state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q       <= 8'h00;
            sync_seen_q <= 1'b0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            sync_seen_q <= sync_seen_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
        end
    end

    assign shadow  = shadow_q;
    assign pending = pending_q;

endmodule

// File: rtl/usb_time_endp.sv
// USB IN endpoint that hands the latest time snapshot to the SIE as an 8-byte DATA packet.
module usb_time_endp
    import usb_time_endp_pkg::*;
#(
    parameter int PKT_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_reset,
    input  logic [7:0] year,
    input  logic [7:0] month,
    input  logic [7:0] day,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [2:0] day_of_week,
    input  logic       dcf77_sync,
    input  logic       dcf77_error,
    output logic [7:0] endpi_data,
    output logic       endpi_valid,
    output logic       endpi_crc16,
    input  logic       endpi_ready
);

    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

    endp_state_t state_q, state_d;
    logic [2:0]  index_q, index_d;
    time_pkt_t   buf_q, buf_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        crc16_q, crc16_d;

    time_pkt_t   shadow;
    logic        pending;
    logic        load_take;
    logic        rearm;

    // A bus reset during LOAD must not consume the pending snapshot.
    assign load_take = (state_q == LOAD) && !usb_reset;
    assign rearm     = (state_q == SEND) && usb_reset;

    time_snapshot u_snapshot (
        .clk         (clk),
        .reset       (reset),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .day_of_week (day_of_week),
        .dcf77_sync  (dcf77_sync),
        .dcf77_error (dcf77_error),
        .load_take   (load_take),
        .rearm       (rearm),
        .shadow      (shadow),
        .pending     (pending)
    );

    // Next-state and registered-output logic for the packet FSM.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = valid_q;
        crc16_d = crc16_q;

        case (state_q)
            EMPTY: begin
                if (pending) state_d = LOAD;
            end
            LOAD: begin
                buf_d   = shadow;
                index_d = 3'd0;
                data_d  = pkt_byte(shadow, 3'd0);
                valid_d = 1'b1;
                crc16_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (endpi_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = EMPTY;
                        index_d = 3'd0;
                        data_d  = 8'h00;
                        valid_d = 1'b0;
                        crc16_d = 1'b0;
                    end else begin
                        index_d = index_q + 3'd1;
                        data_d  = pkt_byte(buf_q, index_q + 3'd1);
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                index_d = 3'd0;
                data_d  = 8'h00;
                valid_d = 1'b0;
                crc16_d = 1'b0;
            end
        endcase

        if (usb_reset) begin
            state_d = EMPTY;
            index_d = 3'd0;
            data_d  = 8'h00;
            valid_d = 1'b0;
            crc16_d = 1'b0;
        end
    end

    // FSM, index, packet buffer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            index_q <= 3'd0;
            buf_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            crc16_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            crc16_q <= crc16_d;
        end
    end

    assign endpi_data  = data_q;
    assign endpi_valid = valid_q;
    assign endpi_crc16 = crc16_q;

endmodule

// File: tb/tb_usb_time_endp.sv
// Scoreboard bench for usb_time_endp: stimulus pushes expected packets, a monitor checks consumed bytes.
module tb_usb_time_endp;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       usb_reset = 1'b0;
    logic [7:0] year = 8'h00, month = 8'h00, day = 8'h00;
    logic [7:0] hour = 8'h00, minute = 8'h00, second = 8'h00;
    logic [2:0] dow = 3'd0;
    logic       sync = 1'b0, err = 1'b0, ready = 1'b0;
    logic [7:0] data;
    logic       valid, crc16;

    usb_time_endp #(.PKT_LEN(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .usb_reset   (usb_reset),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .day_of_week (dow),
        .dcf77_sync  (sync),
        .dcf77_error (err),
        .endpi_data  (data),
        .endpi_valid (valid),
        .endpi_crc16 (crc16),
        .endpi_ready (ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    int          mon_idx = 0;
    int          pkt_no = 0;
    int          ready_limit = 8;
    bit          drv_en = 1'b1;
    bit          sync_flag = 1'b0;
    bit          drop_check = 1'b0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a snapshot is the field values at the seconds change plus status.
    function automatic logic [63:0] model_pkt();
        logic [7:0] st;
        st = {6'b0, err, sync_flag};
        return {st, 5'b0, dow, year, month, day, hour, minute, second};
    endfunction

    // Host side: pulse ready at random while a byte is offered.
    always @(negedge clk) begin
        if (drv_en) begin
            if (ready) ready = 1'b0;
            else if (valid && mon_idx < ready_limit && $urandom_range(0, 2) != 0) ready = 1'b1;
        end
    end

    // Monitor: every consumed byte is compared with the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] head;
        #1;
        if (reset) begin
            check("crc16_follows_valid", crc16, valid);
            if (drop_check) begin
                check("valid_drop_after_byte7", valid, 1'b0);
                drop_check = 1'b0;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1'b1, 1'b0);
                end else begin
                    head = exp_q[0];
                    check($sformatf("pkt%0d_byte%0d", pkt_no, mon_idx), data, head[8*mon_idx +: 8]);
                    $display("pkt %0d byte %0d = %02h", pkt_no, mon_idx, data);
                    mon_idx++;
                    if (mon_idx == 8) begin
                        void'(exp_q.pop_front());
                        mon_idx    = 0;
                        pkt_no++;
                        drop_check = 1'b1;
                    end
                end
            end
        end
    end

    task automatic new_second(input logic [7:0] s, input bit sync_now);
        @(negedge clk);
        second = s;
        sync   = sync_now;
        exp_q.push_back(model_pkt());
        sync_flag = sync_now;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync      = 1'b0;
        sync_flag = 1'b1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (!(exp_q.size() == 0 && !valid) && t < 400) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("drain_timeout", (t >= 400), 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idx(input int k);
        int t = 0;
        while (!(mon_idx == k) && t < 400) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("wait_idx_timeout", (t >= 400), 1'b0);
    endtask

    task automatic rand_fields();
        year   = bcd($urandom_range(0, 99));
        month  = bcd($urandom_range(1, 12));
        day    = bcd($urandom_range(1, 28));
        hour   = bcd($urandom_range(0, 23));
        minute = bcd($urandom_range(0, 59));
        dow    = 3'($urandom_range(1, 7));
    endtask

    function automatic logic [7:0] other_second();
        logic [7:0] s;
        s = second;
        while (s == second) s = bcd($urandom_range(0, 59));
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_valid", valid, 1'b0);
        check("reset_data", data, 8'h00);
        check("reset_crc16", crc16, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset_valid", valid, 1'b0);

        // Basic packet: 23:59:58 on 31.12.99, DoW 5, second -> 59
        year = 8'h99; month = 8'h12; day = 8'h31; hour = 8'h23; minute = 8'h59; dow = 3'd5;
        @(negedge clk);
        second = 8'h58;
        exp_q.push_back(64'h00_05_99_12_31_23_59_58);
        wait_drain();
        @(negedge clk);
        second = 8'h59;
        exp_q.push_back(64'h00_05_99_12_31_23_59_59);
        @(negedge clk);
        @(negedge clk);
        check("latency_valid_low_at_2", valid, 1'b0);
        @(negedge clk);
        check("latency_valid_high_at_3", valid, 1'b1);
        check("first_byte_presented", data, 8'h59);
        wait_drain();

        // Sync flag set, then cleared; error flag sampled
        pulse_sync();
        new_second(8'h00, 1'b0);
        wait_drain();
        new_second(8'h01, 1'b0);
        wait_drain();
        err = 1'b1;
        new_second(8'h02, 1'b1);
        wait_drain();
        err = 1'b0;
        new_second(8'h03, 1'b0);
        wait_drain();

        // Tear-free: second changes after byte 2 consumed
        new_second(8'h04, 1'b0);
        wait_idx(3);
        rand_fields();
        new_second(8'h05, 1'b0);
        wait_drain();

        // usb_reset after byte 4: same snapshot restarts at byte 0
        ready_limit = 5;
        new_second(8'h06, 1'b0);
        wait_idx(5);
        @(negedge clk);
        usb_reset = 1'b1;
        mon_idx   = 0;
        @(negedge clk);
        usb_reset   = 1'b0;
        ready_limit = 8;
        check("usb_reset_valid_drop", valid, 1'b0);
        @(negedge clk);
        check("usb_reset_gap_valid", valid, 1'b0);
        @(negedge clk);
        check("usb_reset_restart_valid", valid, 1'b1);
        check("usb_reset_restart_byte0", data, 8'h06);
        wait_drain();

        // Asynchronous reset mid-packet
        ready_limit = 3;
        new_second(8'h07, 1'b0);
        wait_idx(3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", valid, 1'b0);
        check("async_reset_data", data, 8'h00);
        check("async_reset_crc16", crc16, 1'b0);
        exp_q.delete();
        mon_idx    = 0;
        drop_check = 1'b0;
        sync_flag  = 1'b0;
        second     = 8'h00;
        ready_limit = 8;
        @(negedge clk);
        reset = 1'b1;
        seen_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_valid = seen_valid | valid;
        end
        check("no_valid_after_async_reset", seen_valid, 1'b0);

        // Ready pulses while idle are ignored
        drv_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        drv_en = 1'b1;
        new_second(8'h08, 1'b0);
        wait_drain();

        // Randomized traffic, including sync pulses and mid-packet recaptures
        for (int it = 0; it < 20; it++) begin
            rand_fields();
            err = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) pulse_sync();
            new_second(other_second(), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                wait_idx($urandom_range(1, 7));
                rand_fields();
                new_second(other_second(), 1'b0);
            end
            wait_drain();
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
